// File: rtl/enemy_bullet_pkg.sv
// Shared types, constants and hit-test helper for enemy bullets.
// Jitter option: ENEMY_BULLET_JITTER_EN (see enemy_bullet_frame_timer).
package enemy_bullet_pkg;

  typedef enum logic [1:0] {
    COOLDOWN = 2'b01,
    FLYING   = 2'b10
  } state_t;

  localparam logic [9:0] SCREEN_FLOOR = 10'd469;
  localparam logic [7:0] LFSR_SEED    = 8'hA5;

  // Inclusive rectangle overlap; also used by the player-bullet logic.
  function automatic logic overlap(
    input logic [9:0] a_l, input logic [9:0] a_r,
    input logic [9:0] a_t, input logic [9:0] a_b,
    input logic [9:0] b_l, input logic [9:0] b_r,
    input logic [9:0] b_t, input logic [9:0] b_b
  );
    return (a_l <= b_r) && (b_l <= a_r) &&
           (a_t <= b_b) && (b_t <= a_b);
  endfunction

endpackage

// File: rtl/enemy_bullet_if.sv
// Ship/player geometry in, bullet rectangle, colour and hit out.
// master drives ship/player data; slave is the bullet block.
interface enemy_bullet_if;

  logic       frame_i;
  logic       enable_i;
  logic [9:0] shooter_left_i;
  logic [9:0] shooter_right_i;
  logic [9:0] shooter_bot_i;
  logic [9:0] player_left_i;
  logic [9:0] player_right_i;
  logic [9:0] player_top_i;
  logic [9:0] player_bot_i;
  logic       bullet_active_o;
  logic [9:0] bullet_left_o;
  logic [9:0] bullet_right_o;
  logic [9:0] bullet_top_o;
  logic [9:0] bullet_bot_o;
  logic       hit_player_o;
  logic [3:0] bullet_red_o;
  logic [3:0] bullet_green_o;
  logic [3:0] bullet_blue_o;

  modport master (
    output frame_i, enable_i,
    output shooter_left_i, shooter_right_i, shooter_bot_i,
    output player_left_i, player_right_i,
    output player_top_i, player_bot_i,
    input  bullet_active_o, bullet_left_o, bullet_right_o,
    input  bullet_top_o, bullet_bot_o, hit_player_o,
    input  bullet_red_o, bullet_green_o, bullet_blue_o
  );

  modport slave (
    input  frame_i, enable_i,
    input  shooter_left_i, shooter_right_i, shooter_bot_i,
    input  player_left_i, player_right_i,
    input  player_top_i, player_bot_i,
    output bullet_active_o, bullet_left_o, bullet_right_o,
    output bullet_top_o, bullet_bot_o, hit_player_o,
    output bullet_red_o, bullet_green_o, bullet_blue_o
  );

endinterface

// File: rtl/enemy_bullet_frame_timer.sv
// Saturating frame counter gating the next shot.
// ENEMY_BULLET_JITTER_EN adds an LFSR-randomised target per retirement.
module enemy_bullet_frame_timer
  import enemy_bullet_pkg::*;
#(
  parameter logic [15:0] DELAY = 16'd300
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_frame,
  input  logic i_clr,
  input  logic i_retire,
  output logic o_done
);

  logic [15:0] r_cnt;
  logic [15:0] w_target;

`ifdef ENEMY_BULLET_JITTER_EN
  logic [7:0]  r_lfsr;
  logic [15:0] r_target;
  logic        w_fb;

  // Taps 8,6,5,4 give a maximal-length 255 sequence.
  assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_lfsr   <= LFSR_SEED;
      r_target <= DELAY;
    end else begin
      if (i_frame)
        r_lfsr <= {r_lfsr[6:0], w_fb};
      if (i_retire)
        r_target <= DELAY + {10'd0, r_lfsr[5:0]};
    end
  end

  assign w_target = r_target;
`else
  logic w_unused;
  assign w_unused = i_retire;
  assign w_target = DELAY;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_frame && (r_cnt < w_target))
      r_cnt <= r_cnt + 16'd1;
  end

  assign o_done = (r_cnt == w_target);

endmodule

// File: rtl/enemy_bullet.sv
// Enemy bullet: timed spawn under the ship, per-frame descent, hit/floor.
// Optional macro ENEMY_BULLET_JITTER_EN randomises the cooldown length.
module enemy_bullet
  import enemy_bullet_pkg::*;
#(
  parameter logic [15:0] bullet_delay_p = 16'd300,
  parameter logic [9:0]  speed_p        = 10'd4,
  parameter logic [9:0]  bullet_w_p     = 10'd2,
  parameter logic [9:0]  bullet_h_p     = 10'd10,
  parameter logic [9:0]  floor_p        = SCREEN_FLOOR,
  parameter logic [11:0] color_p        = {4'hF, 4'h0, 4'h0}
) (
  input logic         clk_i,
  input logic         reset_i,
  enemy_bullet_if.slave bus
);

  state_t     r_state, w_state;
  logic [9:0] r_left, w_left;
  logic [9:0] r_top, w_top;
  logic       r_hit, w_hit;
  logic       w_fire, w_retire, w_done;
  logic [9:0] w_spawn_left, w_half_span;
  logic [9:0] w_nt, w_nt_bot;
  logic       w_floor, w_over;

  enemy_bullet_frame_timer #(
    .DELAY (bullet_delay_p)
  ) u_timer (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_frame  (bus.frame_i),
    .i_clr    (w_fire || (r_state == FLYING)),
    .i_retire (w_retire),
    .o_done   (w_done)
  );

  assign w_half_span  = (bus.shooter_right_i - bus.shooter_left_i) >> 1;
  assign w_spawn_left = bus.shooter_left_i + w_half_span
                      - (bullet_w_p >> 1);

  assign w_nt     = r_top + speed_p;
  assign w_nt_bot = w_nt + bullet_h_p;
  assign w_floor  = (w_nt_bot >= floor_p);
  assign w_over   = overlap(r_left, r_left + bullet_w_p,
                            w_nt, w_nt_bot,
                            bus.player_left_i, bus.player_right_i,
                            bus.player_top_i, bus.player_bot_i);

  always_comb begin
    w_state  = r_state;
    w_left   = r_left;
    w_top    = r_top;
    w_hit    = 1'b0;
    w_fire   = 1'b0;
    w_retire = 1'b0;
    unique case (r_state)
      COOLDOWN: begin
        if (w_done && bus.enable_i) begin
          w_fire  = 1'b1;
          w_state = FLYING;
          w_left  = w_spawn_left;
          w_top   = bus.shooter_bot_i + 10'd1;
        end
      end
      FLYING: begin
        if (bus.frame_i) begin
          // Floor wins over a simultaneous player overlap.
          if (w_floor) begin
            w_state  = COOLDOWN;
            w_retire = 1'b1;
          end else if (w_over) begin
            w_state  = COOLDOWN;
            w_retire = 1'b1;
            w_hit    = 1'b1;
          end else begin
            w_top = w_nt;
          end
        end
      end
      default: w_state = COOLDOWN;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= COOLDOWN;
      r_left  <= '0;
      r_top   <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_left  <= w_left;
      r_top   <= w_top;
      r_hit   <= w_hit;
    end
  end

  assign bus.bullet_active_o = (r_state == FLYING);
  assign bus.bullet_left_o   = r_left;
  assign bus.bullet_right_o  = r_left + bullet_w_p;
  assign bus.bullet_top_o    = r_top;
  assign bus.bullet_bot_o    = r_top + bullet_h_p;
  assign bus.hit_player_o    = r_hit;
  assign bus.bullet_red_o    = color_p[11:8];
  assign bus.bullet_green_o  = color_p[7:4];
  assign bus.bullet_blue_o   = color_p[3:0];

endmodule
